// File: rtl/hdc_pkg.sv
// hdc_pkg: shared hypervector sizing and decoder state encoding
package hdc_pkg;
    localparam int HV_DIMENSION = 8;
    localparam int NGRAM_SIZE = 3;
    typedef enum logic [1:0] {IDLE, DECODE, HOLD} dec_state_t;
endpackage

// File: rtl/temporal_decoder_ngram_history.sv
// ngram_history: N-1 recovered hypervectors, exposed pre-shifted for un-binding
module ngram_history #(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic                    clear,
    input  logic [W-1:0]            din,
    output logic [N-2:0][W-1:0]     shifted
);
    logic [N-2:0][W-1:0] r_hist;
    // history shift register; clear wins over shift so a new stream starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else if (clear) begin
            r_hist <= '0;
        end else if (shift_en) begin
            r_hist[0] <= din;
            for (int k = 1; k < N - 1; k++) r_hist[k] <= r_hist[k-1];
        end
    end
    for (genvar g = 0; g < N - 1; g++) begin : g_sh
        assign shifted[g] = r_hist[g] >> (g + 1);
    end
endmodule

// File: rtl/temporal_decoder.sv
// temporal_decoder: recovers per-timestep hypervectors from bound n-grams
module temporal_decoder
    import hdc_pkg::*;
#(
    parameter int HV_DIMENSION = hdc_pkg::HV_DIMENSION,
    parameter int NGRAM_SIZE = hdc_pkg::NGRAM_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hvin_valid,
    output logic                    hvin_ready,
    input  logic [HV_DIMENSION-1:0] hvin,
    input  logic                    history_clear,
    output logic                    hvout_valid,
    input  logic                    hvout_ready,
    output logic [HV_DIMENSION-1:0] hvout
);
    dec_state_t r_state, w_next;
    logic [HV_DIMENSION-1:0] r_in_buf, r_hvout, w_dec;
    logic [NGRAM_SIZE-2:0][HV_DIMENSION-1:0] w_shifted;
    ngram_history #(.W(HV_DIMENSION), .N(NGRAM_SIZE)) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (r_state == DECODE),
        .clear    (r_state == IDLE && history_clear),
        .din      (w_dec),
        .shifted  (w_shifted)
    );
    // un-bind: strip every shifted history term from the captured n-gram
    always_comb begin
        w_dec = r_in_buf;
        for (int k = 0; k < NGRAM_SIZE - 1; k++) w_dec = w_dec ^ w_shifted[k];
    end
    // next state and handshake outputs, decoded from the state register only
    always_comb begin
        w_next = r_state;
        hvin_ready = 1'b0;
        hvout_valid = 1'b0;
        case (r_state)
            IDLE: begin
                hvin_ready = 1'b1;
                w_next = hvin_valid ? DECODE : IDLE;
            end
            DECODE: w_next = HOLD;
            HOLD: begin
                hvout_valid = 1'b1;
                w_next = hvout_ready ? IDLE : HOLD;
            end
            default: w_next = IDLE;
        endcase
    end
    // state, input capture and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_in_buf <= '0;
            r_hvout <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && hvin_valid) r_in_buf <= hvin;
            if (r_state == DECODE) r_hvout <= w_dec;
        end
    end
    assign hvout = r_hvout;
endmodule

// File: tb/tb_temporal_decoder.sv
// tb_temporal_decoder: directed table, corner sequences and encoder loopback
module tb_temporal_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hvin_valid = 1'b0, hvin_ready, history_clear = 1'b0;
    logic hvout_valid, hvout_ready = 1'b1;
    logic [7:0] hvin = '0, hvout;
    int n_chk = 0, n_err = 0;

    temporal_decoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3)) dut (
        .clk(clk), .rst(rst), .hvin_valid(hvin_valid), .hvin_ready(hvin_ready),
        .hvin(hvin), .history_clear(history_clear), .hvout_valid(hvout_valid),
        .hvout_ready(hvout_ready), .hvout(hvout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         clr;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hvin_valid = 1'b0;
        history_clear = 1'b0;
        hvout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", hvin_ready, 1);
        chk("reset_out_valid", hvout_valid, 0);
        chk("reset_hvout", hvout, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fire(input logic [7:0] b, input bit clr);
        int t = 0;
        @(negedge clk);
        while (!hvin_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_fire", hvin_ready, 1);
        hvin_valid = 1'b1;
        hvin = b;
        history_clear = clr;
        @(posedge clk);
        #1;
        hvin_valid = 1'b0;
        history_clear = 1'b0;
        hvin = 8'($urandom);
    endtask

    task automatic wait_valid();
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("in_ready_low_decode", hvin_ready, 0);
        end while (!hvout_valid && lat < 10);
        chk("latency", lat, 2);
    endtask

    task automatic xfer(input logic [7:0] b, input bit clr, input logic [7:0] exp,
                        input int stall, input string nm);
        hvout_ready = (stall == 0);
        fire(b, clr);
        wait_valid();
        chk(nm, hvout, exp);
        for (int i = 0; i < stall; i++) begin
            hvin_valid = 1'b1;
            hvin = 8'($urandom);
            @(negedge clk);
            chk("hold_hvout", hvout, exp);
            chk("hold_out_valid", hvout_valid, 1);
            chk("hold_in_ready", hvin_ready, 0);
        end
        hvout_ready = 1'b1;
        @(posedge clk);
        #1;
        hvin_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl[5];
        logic [7:0] mh[2];
        logic [7:0] h, b;
        bit clr;
        tbl = '{'{8'hA5, 1'b0, 8'hA5}, '{8'h6E, 1'b0, 8'h3C}, '{8'hC7, 1'b0, 8'hF0},
                '{8'h6E, 1'b1, 8'h6E}, '{8'hA5, 1'b0, 8'h92}};
        do_reset();
        for (int i = 0; i < 5; i++) xfer(tbl[i].b, tbl[i].clr, tbl[i].exp, 0, "table");

        do_reset();
        xfer(8'hA5, 1'b0, 8'hA5, 0, "bp_first");
        xfer(8'h6E, 1'b0, 8'h3C, 5, "bp_held");
        xfer(8'hC7, 1'b0, 8'hF0, 0, "bp_after");

        @(negedge clk);
        history_clear = 1'b1;
        @(posedge clk);
        #1;
        history_clear = 1'b0;
        xfer(8'h6E, 1'b0, 8'h6E, 0, "clear_idle");

        do_reset();
        xfer(8'hA5, 1'b0, 8'hA5, 0, "rst_pre");
        hvout_ready = 1'b0;
        fire(8'h6E, 1'b0);
        wait_valid();
        chk("rst_hold_value", hvout, 8'h3C);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", hvout_valid, 0);
        chk("async_hvout", hvout, 0);
        chk("async_in_ready", hvin_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        hvout_ready = 1'b1;
        xfer(8'hC7, 1'b0, 8'hC7, 0, "after_async");

        do_reset();
        mh[0] = '0;
        mh[1] = '0;
        for (int n = 0; n < 1000; n++) begin
            h = 8'($urandom);
            clr = ($urandom_range(0, 49) == 0);
            if (clr) begin
                mh[0] = '0;
                mh[1] = '0;
            end
            b = h ^ (mh[0] >> 1) ^ (mh[1] >> 2);
            mh[1] = mh[0];
            mh[0] = h;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            xfer(b, clr, h, $urandom_range(0, 3), "loopback");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
